vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Parametrised VGA raster timing generator with latency-compensated pixel pipeline. Successor to the fixed 640x480 display block. Horizontal/vertical geometry, sync polarity, colour depth and pixel-source latency are all parameters. Presents request coordinates to the pixel source (snake board renderer, sprite ROM) and re-aligns returned colour with sync and blanking. Sits between the game renderer and the VGA connector pins.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- HSYNC_POL, 0, asserted hsync level (0 = active-low)
- VSYNC_POL, 0, asserted vsync level
- COLOR_W, 4, bits per colour channel
- PIX_LAT, 1, pixel-source latency in cycles, legal range 0..7

- clk25  input  1  pixel clock; all logic on posedge
- rst_n  input  1  asynchronous active-low reset
- rgb  input  3*COLOR_W  {R,G,B} from pixel source, MSB-first
- pix_x  output  HW  request column, HW = $clog2(H_TOTAL)
- pix_y  output  VW  request row, VW = $clog2(V_TOTAL)
- pix_req  output  1  request coordinate is inside the active area
- red_out / green_out / blue_out  output  COLOR_W each  registered colour to DAC
- hsync / vsync  output  1  registered sync
- de  output  1  output pixel is visible
- frame_start  output  1  one-cycle pulse with the first output pixel (0,0) of each frame
- line_start  output  1  one-cycle pulse with output pixel x=0 of each active line

## Operation
- H_TOTAL = sum of H params (default 800); V_TOTAL = sum of V params (default 525).
- Request counters h_cnt, v_cnt: h_cnt increments every cycle, wraps H_TOTAL-1 -> 0; v_cnt increments only on h wrap, wraps V_TOTAL-1 -> 0. Simultaneous wrap at (H_TOTAL-1, V_TOTAL-1) -> (0,0).
- pix_x = h_cnt, pix_y = v_cnt (direct register outputs); pix_req = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
- Raw status from counters: hs_raw asserted for H_ACTIVE+H_FRONT <= h_cnt <= H_ACTIVE+H_FRONT+H_SYNC-1; vs_raw asserted for whole lines V_ACTIVE+V_FRONT .. V_ACTIVE+V_FRONT+V_SYNC-1 (changes on h_cnt = 0); fs_raw = (h_cnt==0 && v_cnt==0); ls_raw = (h_cnt==0 && pix_req).
- {pix_req, hs_raw, vs_raw, fs_raw, ls_raw} pass through a PIX_LAT-deep delay line, then one output register stage.
- Output stage: colour outputs = rgb when delayed pix_req is 1, else all zero. hsync = HSYNC_POL when delayed hs asserted, else ~HSYNC_POL; vsync likewise.
- rgb is sampled exactly PIX_LAT cycles after the matching pix_x/pix_y; the pixel source must honour that latency, no backpressure.

## Timing
- Reset (async assert, rst_n low): h_cnt=0, v_cnt=0, all delay-line stages inactive, colour outputs 0, de=0, frame_start=0, line_start=0, hsync=~HSYNC_POL, vsync=~VSYNC_POL.
- Reset release: first posedge with rst_n high advances h_cnt to 1; request (0,0) was presented during reset, so first frame_start appears PIX_LAT+1 cycles after that first edge.
- Reset mid-frame: counters and pipeline clear immediately; no partial sync pulse is completed.
- Latency from a request coordinate to its output pixel/sync/de = PIX_LAT+1 cycles, identical for all outputs.
- hsync width exactly H_SYNC cycles; vsync width exactly V_SYNC*H_TOTAL cycles; frame period H_TOTAL*V_TOTAL cycles.
- Elaboration error if any geometry param < 1 or PIX_LAT > 7.

## Structure
- Package vga_timing_pkg: default 640x480@60 constants, an 800x600 constant set, function computing counter widths.
- Sub-module vga_delay_line (WIDTH, DEPTH; DEPTH=0 is a wire), async active-low reset to 0, used for the status bundle.

## Test plan
- Defaults, hold rst_n low 5 cycles, release -> hsync/vsync high, de=0 until frame_start at cycle PIX_LAT+1 = 2 after release edge.
- Defaults, run one frame -> 420000 cycles between frame_starts; hsync low 96 cycles starting 656 cycles after line_start; vsync low 1600 cycles.
- PIX_LAT=3, source returns rgb = {pix_x[3:0], pix_y[3:0], 4'hA} delayed 3 cycles -> output pixel at x=5,y=7 shows 12'h57A with de=1; blanked region outputs 0.
- HSYNC_POL=1, VSYNC_POL=1, 800x600 set (40/128/88, 1/4/23) -> sync pulses high, H_TOTAL 1056, V_TOTAL 628.
- Reset asserted at h_cnt=700,v_cnt=490 (inside vsync) -> vsync deasserts asynchronously, pix_x=pix_y=0 immediately.
- Wrap corner: observe (799,524) -> next request (0,0), frame_start PIX_LAT+1 cycles later, line_start coincident.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, status bundle type and width helper.
package vga_timing_pkg;

  // 640x480@60, 25.175 MHz pixel clock
  localparam int VGA640_H_ACTIVE = 640;
  localparam int VGA640_H_FRONT  = 16;
  localparam int VGA640_H_SYNC   = 96;
  localparam int VGA640_H_BACK   = 48;
  localparam int VGA640_V_ACTIVE = 480;
  localparam int VGA640_V_FRONT  = 10;
  localparam int VGA640_V_SYNC   = 2;
  localparam int VGA640_V_BACK   = 33;

  // 800x600@60, 40 MHz pixel clock, positive syncs
  localparam int SVGA800_H_ACTIVE = 800;
  localparam int SVGA800_H_FRONT  = 40;
  localparam int SVGA800_H_SYNC   = 128;
  localparam int SVGA800_H_BACK   = 88;
  localparam int SVGA800_V_ACTIVE = 600;
  localparam int SVGA800_V_FRONT  = 1;
  localparam int SVGA800_V_SYNC   = 4;
  localparam int SVGA800_V_BACK   = 23;

  // Per-pixel status that travels alongside the pixel-source latency
  typedef struct packed {
    logic req;  // coordinate inside active area
    logic hs;   // inside hsync pulse
    logic vs;   // inside vsync lines
    logic fs;   // first pixel of frame
    logic ls;   // first pixel of an active line
  } vga_stat_t;

  // Counter width for a 0..total-1 counter
  function automatic int cnt_w(input int total);
    return (total > 1) ? $clog2(total) : 1;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth register delay line; DEPTH=0 degenerates to a wire.
module vga_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
    assign dout = din;
  end else begin : g_pipe
    logic [DEPTH-1:0][WIDTH-1:0] stg;

    // Shift one stage per clock; reset flushes every stage to inactive
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stg <= '0;
      end else begin
        stg[0] <= din;
        for (int i = 1; i < DEPTH; i++) stg[i] <= stg[i-1];
      end
    end

    assign dout = stg[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster generator. Request coordinates go out to the pixel
// source; the status bundle is delayed to match the source latency so colour,
// sync and blanking leave together through one output register.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE  = VGA640_H_ACTIVE,
  parameter int H_FRONT   = VGA640_H_FRONT,
  parameter int H_SYNC    = VGA640_H_SYNC,
  parameter int H_BACK    = VGA640_H_BACK,
  parameter int V_ACTIVE  = VGA640_V_ACTIVE,
  parameter int V_FRONT   = VGA640_V_FRONT,
  parameter int V_SYNC    = VGA640_V_SYNC,
  parameter int V_BACK    = VGA640_V_BACK,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int COLOR_W   = 4,
  parameter int PIX_LAT   = 1,
  localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK,
  localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK,
  localparam int HW       = cnt_w(H_TOTAL),
  localparam int VW       = cnt_w(V_TOTAL)
) (
  input  logic                 clk25,
  input  logic                 rst_n,
  input  logic [3*COLOR_W-1:0] rgb,
  output logic [HW-1:0]        pix_x,
  output logic [VW-1:0]        pix_y,
  output logic                 pix_req,
  output logic [COLOR_W-1:0]   red_out,
  output logic [COLOR_W-1:0]   green_out,
  output logic [COLOR_W-1:0]   blue_out,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 de,
  output logic                 frame_start,
  output logic                 line_start
);

  if (H_ACTIVE < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
      V_ACTIVE < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1 ||
      COLOR_W < 1 || PIX_LAT < 0 || PIX_LAT > 7) begin : g_bad_param
    $error("vga_timing_gen: geometry params must be >= 1 and PIX_LAT in 0..7");
  end

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_FIRST = HW'(H_ACTIVE + H_FRONT);
  localparam logic [HW-1:0] HS_LAST  = HW'(H_ACTIVE + H_FRONT + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_FIRST = VW'(V_ACTIVE + V_FRONT);
  localparam logic [VW-1:0] VS_LAST  = VW'(V_ACTIVE + V_FRONT + V_SYNC - 1);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  vga_stat_t     stat_raw;
  vga_stat_t     stat_dly;

  // Raster counters: h every cycle, v on h wrap, both wrap to (0,0)
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  assign pix_x   = h_cnt;
  assign pix_y   = v_cnt;
  assign pix_req = stat_raw.req;

  // Status decoded from the request coordinate
  always_comb begin
    stat_raw     = '0;
    stat_raw.req = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    stat_raw.hs  = (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
    stat_raw.vs  = (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);
    stat_raw.fs  = (h_cnt == '0) && (v_cnt == '0);
    stat_raw.ls  = (h_cnt == '0) && stat_raw.req;
  end

  // Hold status back by the pixel-source latency so it meets the returned rgb
  vga_delay_line #(
    .WIDTH ($bits(vga_stat_t)),
    .DEPTH (PIX_LAT)
  ) u_stat_dly (
    .clk   (clk25),
    .rst_n (rst_n),
    .din   (stat_raw),
    .dout  (stat_dly)
  );

  // Output register: blank colour outside active area, apply sync polarity
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      red_out     <= '0;
      green_out   <= '0;
      blue_out    <= '0;
      de          <= 1'b0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
    end else begin
      red_out     <= stat_dly.req ? rgb[3*COLOR_W-1 -: COLOR_W] : '0;
      green_out   <= stat_dly.req ? rgb[2*COLOR_W-1 -: COLOR_W] : '0;
      blue_out    <= stat_dly.req ? rgb[COLOR_W-1:0]            : '0;
      de          <= stat_dly.req;
      frame_start <= stat_dly.fs;
      line_start  <= stat_dly.ls;
      hsync       <= stat_dly.hs ? HSYNC_POL : ~HSYNC_POL;
      vsync       <= stat_dly.vs ? VSYNC_POL : ~VSYNC_POL;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (640x480 defaults, 800x600 with
// positive syncs and zero latency, and a tiny 15x13 raster with PIX_LAT=3 so
// whole frames fit in a short run). Pixels of the tiny raster are checked by
// a scoreboard; sync/line/frame intervals are checked from edge timestamps.
module tb_vga_timing_gen;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  function automatic int at(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1000000;
  endfunction

  // ---------------- 640x480 defaults, PIX_LAT=1
  logic [11:0] rgb_def = 12'h123;
  logic [9:0]  x_def, y_def;
  logic [3:0]  r_def, g_def, b_def;
  logic        req_def, hs_def, vs_def, de_def, fs_def, ls_def;

  vga_timing_gen u_def (
    .clk25(clk), .rst_n(rst_n), .rgb(rgb_def),
    .pix_x(x_def), .pix_y(y_def), .pix_req(req_def),
    .red_out(r_def), .green_out(g_def), .blue_out(b_def),
    .hsync(hs_def), .vsync(vs_def), .de(de_def),
    .frame_start(fs_def), .line_start(ls_def)
  );

  // ---------------- 800x600, positive syncs, PIX_LAT=0
  logic [11:0] rgb_hi = 12'h000;
  logic [10:0] x_hi;
  logic [9:0]  y_hi;
  logic [3:0]  r_hi, g_hi, b_hi;
  logic        req_hi, hs_hi, vs_hi, de_hi, fs_hi, ls_hi;

  vga_timing_gen #(
    .H_ACTIVE(800), .H_FRONT(40), .H_SYNC(128), .H_BACK(88),
    .V_ACTIVE(600), .V_FRONT(1),  .V_SYNC(4),   .V_BACK(23),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .COLOR_W(4), .PIX_LAT(0)
  ) u_hi (
    .clk25(clk), .rst_n(rst_n), .rgb(rgb_hi),
    .pix_x(x_hi), .pix_y(y_hi), .pix_req(req_hi),
    .red_out(r_hi), .green_out(g_hi), .blue_out(b_hi),
    .hsync(hs_hi), .vsync(vs_hi), .de(de_hi),
    .frame_start(fs_hi), .line_start(ls_hi)
  );

  // ---------------- tiny raster 8/2/3/2 x 8/1/2/2 (15x13), PIX_LAT=3
  logic [11:0] rgb_sm;
  logic [3:0]  x_sm, y_sm;
  logic [3:0]  r_sm, g_sm, b_sm;
  logic        req_sm, hs_sm, vs_sm, de_sm, fs_sm, ls_sm;

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_ACTIVE(8), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .COLOR_W(4), .PIX_LAT(3)
  ) u_sm (
    .clk25(clk), .rst_n(rst_n), .rgb(rgb_sm),
    .pix_x(x_sm), .pix_y(y_sm), .pix_req(req_sm),
    .red_out(r_sm), .green_out(g_sm), .blue_out(b_sm),
    .hsync(hs_sm), .vsync(vs_sm), .de(de_sm),
    .frame_start(fs_sm), .line_start(ls_sm)
  );

  // Pixel source with 3-cycle latency returning {x, y, A}
  logic [2:0][11:0] src_pipe;
  always @(posedge clk) src_pipe <= {src_pipe[1:0], {x_sm, y_sm, 4'hA}};
  assign rgb_sm = src_pipe[2];

  // ---------------- scoreboard for the tiny raster
  typedef struct { int x; int y; logic [11:0] rgb; } pix_t;
  pix_t exp_q[$];
  pix_t e;
  logic mon_en = 1'b0;

  task automatic push_frame();
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++) begin
        pix_t p;
        p.x = x; p.y = y; p.rgb = {4'(x), 4'(y), 4'hA};
        exp_q.push_back(p);
      end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (de_sm) begin
        if (exp_q.size() == 0) begin
          chk("sm_extra_de", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("sm_rgb", {r_sm, g_sm, b_sm}, e.rgb);
          chk("sm_fs", fs_sm, (e.x == 0 && e.y == 0) ? 1 : 0);
          chk("sm_ls", ls_sm, (e.x == 0) ? 1 : 0);
          if (e.x == 5 && e.y == 7) chk("sm_px57", {r_sm, g_sm, b_sm}, 12'h57A);
        end
      end else begin
        chk("sm_blank", {r_sm, g_sm, b_sm, fs_sm, ls_sm}, 0);
      end
    end
  end

  // ---------------- edge timestamp recorder
  logic rec_en = 1'b0;
  int def_ls_q[$], def_hsf_q[$], def_hsr_q[$];
  int hi_ls_q[$],  hi_hsf_q[$],  hi_hsr_q[$];
  int sm_fs_q[$],  sm_ls_q[$],   sm_hsf_q[$], sm_hsr_q[$], sm_vsf_q[$], sm_vsr_q[$];
  logic p_hs_def = 1'b1, p_hs_hi = 1'b0, p_hs_sm = 1'b1, p_vs_sm = 1'b1;

  always @(negedge clk) begin
    if (rec_en) begin
      if (ls_def) def_ls_q.push_back(cyc);
      if (hs_def != p_hs_def) begin
        if (hs_def) def_hsr_q.push_back(cyc); else def_hsf_q.push_back(cyc);
      end
      if (ls_hi) hi_ls_q.push_back(cyc);
      if (hs_hi != p_hs_hi) begin
        if (hs_hi) hi_hsr_q.push_back(cyc); else hi_hsf_q.push_back(cyc);
      end
      if (fs_sm) sm_fs_q.push_back(cyc);
      if (ls_sm) sm_ls_q.push_back(cyc);
      if (hs_sm != p_hs_sm) begin
        if (hs_sm) sm_hsr_q.push_back(cyc); else sm_hsf_q.push_back(cyc);
      end
      if (vs_sm != p_vs_sm) begin
        if (vs_sm) sm_vsr_q.push_back(cyc); else sm_vsf_q.push_back(cyc);
      end
    end
    p_hs_def <= hs_def;
    p_hs_hi  <= hs_hi;
    p_hs_sm  <= hs_sm;
    p_vs_sm  <= vs_sm;
  end

  // ---------------- directed sequence
  initial begin
    #1 rst_n = 1'b0;
    repeat (5) @(negedge clk);

    chk("rst_def_hs",  hs_def, 1);
    chk("rst_def_vs",  vs_def, 1);
    chk("rst_def_de",  de_def, 0);
    chk("rst_def_fs",  fs_def, 0);
    chk("rst_def_ls",  ls_def, 0);
    chk("rst_def_rgb", {r_def, g_def, b_def}, 0);
    chk("rst_def_xy",  {x_def, y_def}, 0);
    chk("rst_def_req", req_def, 1);
    chk("rst_hi_hs",   hs_hi, 0);
    chk("rst_hi_vs",   vs_hi, 0);
    chk("rst_sm_sync", {hs_sm, vs_sm, de_sm}, 3'b110);

    push_frame();
    mon_en = 1'b1;
    rec_en = 1'b1;
    rst_n  = 1'b1;

    fork
      begin
        @(negedge clk);
        chk("def_fs_e1", fs_def, 0);
        chk("def_de_e1", de_def, 0);
        chk("def_x_e1",  x_def, 1);
        chk("hi_fs_e1",  fs_hi, 1);
        chk("hi_de_e1",  de_hi, 1);
        @(negedge clk);
        chk("def_fs_e2",  fs_def, 1);
        chk("def_ls_e2",  ls_def, 1);
        chk("def_de_e2",  de_def, 1);
        chk("def_rgb_e2", {r_def, g_def, b_def}, 12'h123);
        chk("def_hs_e2",  hs_def, 1);
        repeat (2200) @(negedge clk);
        chk("def_hs_ofs", at(def_hsf_q, 0) - at(def_ls_q, 0), 656);
        chk("def_hs_w",   at(def_hsr_q, 0) - at(def_hsf_q, 0), 96);
        chk("def_line",   at(def_ls_q, 1)  - at(def_ls_q, 0), 800);
        chk("hi_hs_ofs",  at(hi_hsr_q, 0)  - at(hi_ls_q, 0), 840);
        chk("hi_hs_w",    at(hi_hsf_q, 0)  - at(hi_hsr_q, 0), 128);
        chk("hi_line",    at(hi_ls_q, 1)   - at(hi_ls_q, 0), 1056);
        chk("sm_frame",   at(sm_fs_q, 1)   - at(sm_fs_q, 0), 195);
        chk("sm_vs_ofs",  at(sm_vsf_q, 0)  - at(sm_fs_q, 0), 135);
        chk("sm_vs_w",    at(sm_vsr_q, 0)  - at(sm_vsf_q, 0), 30);
        chk("sm_hs_ofs",  at(sm_hsf_q, 0)  - at(sm_ls_q, 0), 10);
        chk("sm_hs_w",    at(sm_hsr_q, 0)  - at(sm_hsf_q, 0), 3);
      end
      begin
        int n;
        for (int f = 0; f < 2; f++) begin
          if (f == 1) push_frame();
          n = 0;
          while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
          end
          if (exp_q.size() != 0) chk("sm_drain", exp_q.size(), 0);
        end
        repeat (20) @(negedge clk);
        mon_en = 1'b0;
      end
    join

    // Wrap corner: (14,12) -> (0,0), frame_start 4 cycles later
    begin
      int n;
      n = 0;
      while (!(x_sm == 4'd14 && y_sm == 4'd12) && n < 400) begin
        @(negedge clk);
        n++;
      end
      chk("sm_wrap_found", (x_sm == 4'd14 && y_sm == 4'd12) ? 1 : 0, 1);
      @(negedge clk);
      chk("sm_wrap_xy", {x_sm, y_sm}, 0);
      repeat (3) @(negedge clk);
      chk("sm_wrap_fs_early", fs_sm, 0);
      @(negedge clk);
      chk("sm_wrap_fs", fs_sm, 1);
      chk("sm_wrap_ls", ls_sm, 1);
      chk("sm_wrap_de", de_sm, 1);
    end

    // Reset while inside vsync: outputs clear before any clock edge
    begin
      int n;
      n = 0;
      while (!(x_sm == 4'd5 && y_sm == 4'd10) && n < 400) begin
        @(negedge clk);
        n++;
      end
      chk("sm_vs_before_rst", vs_sm, 0);
      rec_en = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("sm_rst_vs", vs_sm, 1);
      chk("sm_rst_hs", hs_sm, 1);
      chk("sm_rst_xy", {x_sm, y_sm}, 0);
      chk("sm_rst_de", de_sm, 0);
    end

    repeat (2) @(negedge clk);
    chk("sm_q_left", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
